bht_gshare: RTL and testbench
=============================

// Module: bht_gshare
// PURPOSE
//  Gshare branch history table: array of saturating counters indexed by fetch PC XOR global history.
//  Sits upstream of fetch redirect; gives a taken/not-taken prediction per looked-up branch and is
//  trained by the resolve stage. Counter semantics match the single-entry saturating counter, scaled to a table.
// PARAMETERS
//  IDX_W   6  table index width; table holds 2**IDX_W counters
//  CW      2  counter width; prediction = counter MSB
//  HIST_W  4  global history register (GHR) width, 1 <= HIST_W <= IDX_W
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  reset         in   1       synchronous, active-high
//  ready         out  1       1 = table initialised, ports live
//  lookup_valid  in   1       lookup request this cycle
//  lookup_pc     in   32      branch PC (word aligned)
//  pred_valid    out  1       registered response to lookup
//  pred_taken    out  1       predicted direction
//  pred_idx      out  IDX_W   index used; carried down pipe, returned on upd_idx
//  upd_valid     in   1       resolved branch training request
//  upd_idx       in   IDX_W   index from the original pred_idx
//  upd_taken     in   1       actual outcome
// BEHAVIOUR
//  States: INIT, RUN. reset (any cycle, incl. mid-RUN or mid-INIT) -> INIT, init_ptr=0, GHR=0,
//   ready=0, pred_valid=0, pred_taken=0, pred_idx=0.
//  INIT: each cycle write WEAK_NT = 2**(CW-1)-1 (2'b01) to entry init_ptr, init_ptr++.
//   After writing entry 2**IDX_W-1 -> RUN; ready=1 from the next cycle (ready after 2**IDX_W cycles).
//   lookup_valid/upd_valid ignored in INIT: no response, no counter or GHR change.
//  Index: idx = lookup_pc[IDX_W+1:2] ^ {{(IDX_W-HIST_W){1'b0}}, GHR}.
//  Lookup (RUN): 1-cycle latency. Cycle after lookup_valid: pred_valid=1, pred_taken=table[idx][CW-1],
//   pred_idx=idx. No lookup -> pred_valid=0, pred_taken/pred_idx hold.
//  Update (RUN): table[upd_idx] <= taken ? min(c+1, 2**CW-1) : max(c-1, 0); no wrap at either end.
//   GHR <= {GHR[HIST_W-2:0], upd_taken} (HIST_W=1: GHR <= upd_taken). GHR never changes otherwise.
//  Same-cycle lookup+update: lookup uses pre-update GHR and pre-update counter (read-first), even
//   when idx == upd_idx. New values visible to lookups from the following cycle.
//  Back-to-back updates to one index each apply once per cycle; no coalescing, no lost updates.
//  Counter arithmetic in CW bits; saturation decided before add/sub so no overflow is ever stored.
// STRUCTURE
//  Shared include bpred_defs.vh: state encodings (ST_INIT, ST_RUN), WEAK_NT and SAT_MAX as
//   functions of CW, default IDX_W/CW/HIST_W.
//  Sub-module sat_next (combinational, param CW): cur, taken -> next, pure saturating step; reused
//   by any future local/tournament predictor. Table is a register array, one write port
//   (init write or update, muxed by state), one read port.
// TESTING
//  T1 reset, hold ready watch -> ready=0 for exactly 64 cycles, 1 at cycle 65; every entry reads 2'b01.
//  T2 after init, lookup pc=0x0000_0010 -> next cycle pred_valid=1, pred_idx=4, pred_taken=0.
//  T3 upd_idx=4 taken x2 -> counter 01->10->11, GHR=4'b0011; 3rd taken stays 11.
//   lookup pc=0x10 (idx=4^3=7) -> pred_taken=0; pc=0x1C (idx=7^3=4) -> pred_taken=1.
//  T4 counter at 00, upd not-taken x3 -> stays 00, GHR shifts in 0s each time.
//  T5 same cycle lookup idx 5 and upd_idx=5 taken with counter=01 -> pred_taken=0 (old value);
//   lookup next cycle, recomputed idx -> value reflects 10.
//  T6 reset asserted mid-RUN during lookup and update -> no write, pred_valid=0 next cycle, GHR=0,
//   full 64-cycle INIT re-run; lookups during INIT get no pred_valid.

Source files
------------

// File: rtl/bht_gshare_pkg.sv
// rtl/bht_gshare_pkg.sv - shared defaults, state encoding and counter constants for gshare predictors
package bht_gshare_pkg;

  localparam int DEF_IDX_W  = 6;
  localparam int DEF_CW     = 2;
  localparam int DEF_HIST_W = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Weakly-not-taken: the value just below the taken threshold.
  function automatic int weak_nt(input int cw);
    return (1 << (cw - 1)) - 1;
  endfunction

  function automatic int sat_max(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/bht_gshare_sat_next.sv
// rtl/bht_gshare_sat_next.sv - pure saturating counter step, shared by table-based predictors
module bht_gshare_sat_next
  import bht_gshare_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic [CW-1:0] i_cur,
  input  logic          i_taken,
  output logic [CW-1:0] o_next
);

  localparam logic [CW-1:0] SAT_MAX = CW'(sat_max(CW));

  // Saturation is tested before the add/sub so the result never wraps.
  always_comb begin
    o_next = i_cur;
    if (i_taken) begin
      if (i_cur != SAT_MAX) o_next = i_cur + 1'b1;
    end else begin
      if (i_cur != '0) o_next = i_cur - 1'b1;
    end
  end

endmodule

// File: rtl/bht_gshare.sv
// rtl/bht_gshare.sv - gshare branch history table: counters indexed by PC XOR global history
module bht_gshare
  import bht_gshare_pkg::*;
#(
  parameter int IDX_W  = DEF_IDX_W,
  parameter int CW     = DEF_CW,
  parameter int HIST_W = DEF_HIST_W
) (
  input  logic             clk,
  input  logic             reset,
  output logic             ready,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [CW-1:0]    WEAK_NT  = CW'(weak_nt(CW));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_init_ptr;
  logic [HIST_W-1:0] r_ghr;
  logic [CW-1:0]     r_table [DEPTH];

  logic [IDX_W-1:0]  w_idx;
  logic [CW-1:0]     w_upd_next;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [CW-1:0]     w_wdata;
  logic              w_run_lookup;
  logic              w_unused_pc;

  assign w_unused_pc  = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};
  assign w_idx        = lookup_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign ready        = (r_state == ST_RUN);
  assign w_run_lookup = ready & lookup_valid;

  bht_gshare_sat_next #(.CW(CW)) u_sat_next (
    .i_cur   (r_table[upd_idx]),
    .i_taken (upd_taken),
    .o_next  (w_upd_next)
  );

  // Single write port: INIT sweep owns it until the table is filled, then training does.
  always_comb begin
    w_state_next = r_state;
    w_we         = 1'b0;
    w_waddr      = upd_idx;
    w_wdata      = w_upd_next;
    case (r_state)
      ST_INIT: begin
        w_we    = 1'b1;
        w_waddr = r_init_ptr;
        w_wdata = WEAK_NT;
        if (r_init_ptr == LAST_IDX) w_state_next = ST_RUN;
      end
      ST_RUN: w_we = upd_valid;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_ptr <= '0;
      r_ghr      <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx   <= '0;
    end else begin
      pred_valid <= w_run_lookup;
      if (r_state == ST_INIT) r_init_ptr <= r_init_ptr + 1'b1;
      if (w_run_lookup) begin
        pred_taken <= r_table[w_idx][CW-1];
        pred_idx   <= w_idx;
      end
      if (ready && upd_valid) r_ghr <= (r_ghr << 1) | HIST_W'(upd_taken);
    end
  end

  // Read-first: same-cycle lookups above see the value before this write lands.
  always_ff @(posedge clk) begin
    if (!reset && w_we) r_table[w_waddr] <= w_wdata;
  end

endmodule

// File: tb/tb_bht_gshare.sv
// tb/tb_bht_gshare.sv - self-checking bench for bht_gshare against a table/history reference model
module tb_bht_gshare;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ready;
  logic       lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic       pred_valid;
  logic       pred_taken;
  logic [5:0] pred_idx;
  logic       upd_valid = 1'b0;
  logic [5:0] upd_idx = '0;
  logic       upd_taken = 1'b0;

  int checks = 0;
  int errors = 0;

  int m_tbl [64];
  int m_ghr = 0;
  int m_cnt = 0;
  bit m_run = 1'b0;
  bit e_pv  = 1'b0;
  bit e_pt  = 1'b0;
  int e_pi  = 0;

  always #5 clk = ~clk;

  bht_gshare dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_idx     (pred_idx),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken)
  );

  // PC whose index field lands on idx under the model's current history.
  function automatic int pc_for(input int idx);
    return ((idx ^ m_ghr) & 63) << 2;
  endfunction

  task automatic step(input bit rst, input bit lv, input int pc, input bit uv, input int uidx, input bit ut);
    int idx;
    reset        = rst;
    lookup_valid = lv;
    lookup_pc    = pc;
    upd_valid    = uv;
    upd_idx      = uidx[5:0];
    upd_taken    = ut;
    @(posedge clk);
    #1;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      m_ghr = 0;
      e_pv  = 1'b0;
      e_pt  = 1'b0;
      e_pi  = 0;
      for (int i = 0; i < 64; i++) m_tbl[i] = 1;
    end else if (!m_run) begin
      m_cnt++;
      e_pv = 1'b0;
      if (m_cnt == 64) m_run = 1'b1;
    end else begin
      idx  = ((pc >> 2) & 63) ^ m_ghr;
      e_pv = lv;
      if (lv) begin
        e_pt = (m_tbl[idx] >= 2);
        e_pi = idx;
      end
      if (uv) begin
        if (ut) m_tbl[uidx] = (m_tbl[uidx] == 3) ? 3 : m_tbl[uidx] + 1;
        else    m_tbl[uidx] = (m_tbl[uidx] == 0) ? 0 : m_tbl[uidx] - 1;
        m_ghr = ((m_ghr << 1) | int'(ut)) & 15;
      end
    end
    reset        = 1'b0;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
  endtask

  task automatic test_reset;
    bit exp_ready;
    step(1, 0, 0, 0, 0, 0);
    checks++;
    if ({ready, pred_valid, pred_taken, pred_idx} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b pv=%0b pt=%0b idx=%0d, expected all 0", ready, pred_valid, pred_taken, pred_idx);
    end
    for (int i = 2; i <= 65; i++) begin
      step(0, 1'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 63)), 1'($urandom));
      exp_ready = (i == 65);
      checks++;
      if (ready !== exp_ready || pred_valid !== 1'b0) begin
        errors++;
        $display("FAIL init_ready cycle %0d: got ready=%0b pv=%0b, expected ready=%0b pv=0", i, ready, pred_valid, exp_ready);
      end
    end
  endtask

  task automatic test_init_entries;
    for (int i = 0; i < 64; i++) begin
      step(0, 1, i * 4, 0, 0, 0);
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'(i)) begin
        errors++;
        $display("FAIL init_entry %0d: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=%0d", i, pred_valid, pred_taken, pred_idx, i);
      end
    end
  endtask

  task automatic test_lookup_basic;
    step(0, 1, 32'h10, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'd4) begin
      errors++;
      $display("FAIL lookup_basic: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=4", pred_valid, pred_taken, pred_idx);
    end
    step(0, 0, 0, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_idx !== 6'd4) begin
      errors++;
      $display("FAIL lookup_hold: got pv=%0b pt=%0b idx=%0d, expected pv=0 pt=0 idx=4", pred_valid, pred_taken, pred_idx);
    end
  endtask

  task automatic test_saturate_up;
    step(0, 0, 0, 1, 4, 1);
    step(0, 0, 0, 1, 4, 1);
    step(0, 1, 32'h10, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'd7) begin
      errors++;
      $display("FAIL sat_up_idx7: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=7", pred_valid, pred_taken, pred_idx);
    end
    step(0, 1, 32'h1C, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_idx !== 6'd4) begin
      errors++;
      $display("FAIL sat_up_idx4: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=1 idx=4", pred_valid, pred_taken, pred_idx);
    end
    step(0, 0, 0, 1, 4, 1);
    step(0, 0, 0, 1, 4, 0);
    step(0, 1, pc_for(4), 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_idx !== 6'd4 || m_tbl[4] != 2) begin
      errors++;
      $display("FAIL sat_up_nowrap: got pt=%0b idx=%0d, expected pt=1 idx=4 (model cnt %0d)", pred_taken, pred_idx, m_tbl[4]);
    end
  endtask

  task automatic test_saturate_down;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 9, 0);
    step(0, 1, 0, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_idx !== 6'd0) begin
      errors++;
      $display("FAIL sat_down_ghr: got pv=%0b idx=%0d, expected pv=1 idx=0", pred_valid, pred_idx);
    end
    step(0, 0, 0, 1, 9, 1);
    step(0, 1, pc_for(9), 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b0 || pred_idx !== 6'd9) begin
      errors++;
      $display("FAIL sat_down_nowrap: got pt=%0b idx=%0d, expected pt=0 idx=9", pred_taken, pred_idx);
    end
  endtask

  task automatic test_read_first;
    step(0, 1, pc_for(5), 1, 5, 1);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'd5) begin
      errors++;
      $display("FAIL read_first_old: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=5", pred_valid, pred_taken, pred_idx);
    end
    step(0, 1, pc_for(5), 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_idx !== 6'd5) begin
      errors++;
      $display("FAIL read_first_new: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=1 idx=5", pred_valid, pred_taken, pred_idx);
    end
  endtask

  task automatic test_back_to_back;
    step(0, 0, 0, 1, 12, 1);
    step(0, 0, 0, 1, 12, 1);
    step(0, 0, 0, 1, 12, 0);
    step(0, 1, pc_for(12), 0, 0, 0);
    checks++;
    if (pred_taken !== 1'b1 || pred_idx !== 6'd12) begin
      errors++;
      $display("FAIL back_to_back: got pt=%0b idx=%0d, expected pt=1 idx=12", pred_taken, pred_idx);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(0, 1'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom));
      checks++;
      if (ready !== m_run || pred_valid !== e_pv || pred_taken !== e_pt || pred_idx !== 6'(e_pi)) begin
        errors++;
        $display("FAIL random cycle %0d: got rdy=%0b pv=%0b pt=%0b idx=%0d, expected rdy=%0b pv=%0b pt=%0b idx=%0d",
                 i, ready, pred_valid, pred_taken, pred_idx, m_run, e_pv, e_pt, e_pi);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    bit exp_ready;
    step(1, 1, 32'h44, 1, 20, 1);
    checks++;
    if ({ready, pred_valid, pred_taken, pred_idx} !== 9'b0) begin
      errors++;
      $display("FAIL midrun_reset: got ready=%0b pv=%0b pt=%0b idx=%0d, expected all 0", ready, pred_valid, pred_taken, pred_idx);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 1, $urandom, 1, int'($urandom_range(0, 63)), 1'($urandom));
      checks++;
      if (ready !== 1'b0 || pred_valid !== 1'b0) begin
        errors++;
        $display("FAIL midinit_traffic %0d: got ready=%0b pv=%0b, expected 0 0", i, ready, pred_valid);
      end
    end
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      step(0, 1, $urandom, 1, int'($urandom_range(0, 63)), 1'($urandom));
      exp_ready = (i == 64);
      checks++;
      if (ready !== exp_ready || pred_valid !== 1'b0) begin
        errors++;
        $display("FAIL reinit_ready %0d: got ready=%0b pv=%0b, expected ready=%0b pv=0", i, ready, pred_valid, exp_ready);
      end
    end
    step(0, 1, 32'h10, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'd4) begin
      errors++;
      $display("FAIL reinit_entry4: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=4", pred_valid, pred_taken, pred_idx);
    end
    step(0, 1, 32'h30, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_idx !== 6'd12) begin
      errors++;
      $display("FAIL reinit_entry12: got pv=%0b pt=%0b idx=%0d, expected pv=1 pt=0 idx=12", pred_valid, pred_taken, pred_idx);
    end
  endtask

  initial begin
    test_reset;
    test_init_entries;
    test_lookup_basic;
    test_saturate_up;
    test_saturate_down;
    test_read_first;
    test_back_to_back;
    test_random;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
